// File: rtl/eth_tx_port_arbiter.sv
// -----------------------------------------------------------------------------
// eth_tx_port_arbiter
//
// Frame-atomic round-robin arbiter that merges CHANNELS AXI-Stream TX sources
// into one registered stream towards the MAC TX FIFO. Frames longer than
// MAX_BEATS are cut: the last forwarded beat is marked tlast=1 with the
// bad-frame flag (tuser[0]) set, and the rest of the source frame is drained
// and discarded.
//
// Optional feature (macro ETH_ARB_FRAME_CNT_EN):
//   adds output frame_count, one 32-bit wrapping counter per channel that
//   counts completed frames (normal end or truncation).
//
// Ports:
//   clock, resetn         single rising-edge clock, async active-low reset
//   s_axis_tdata/tkeep/tuser/tvalid/tlast  flattened per-channel sources,
//                         channel i occupies slice i
//   s_axis_tready         per-channel ready (only the granted bit can be high)
//   m_axis_tdata/tkeep/tuser/tvalid/tlast  registered merged output
//   m_axis_tready         downstream ready
//   grant                 currently / last granted channel
//   busy                  high while a frame is being passed or dropped
//   oversize              one-cycle pulse on the channel whose frame was cut
//   frame_count           (ETH_ARB_FRAME_CNT_EN only) per-channel frame count
// -----------------------------------------------------------------------------
module eth_tx_port_arbiter #(
    parameter int CHANNELS   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1,
    parameter int MAX_BEATS  = 1152
) (
    input  logic                                  clock,
    input  logic                                  resetn,
    input  logic [CHANNELS*DATA_WIDTH-1:0]        s_axis_tdata,
    input  logic [CHANNELS*(DATA_WIDTH/8)-1:0]    s_axis_tkeep,
    input  logic [CHANNELS*USER_WIDTH-1:0]        s_axis_tuser,
    input  logic [CHANNELS-1:0]                   s_axis_tvalid,
    input  logic [CHANNELS-1:0]                   s_axis_tlast,
    output logic [CHANNELS-1:0]                   s_axis_tready,
    output logic [DATA_WIDTH-1:0]                 m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]               m_axis_tkeep,
    output logic [USER_WIDTH-1:0]                 m_axis_tuser,
    output logic                                  m_axis_tvalid,
    output logic                                  m_axis_tlast,
    input  logic                                  m_axis_tready,
    output logic [$clog2(CHANNELS)-1:0]           grant,
    output logic                                  busy,
    output logic [CHANNELS-1:0]                   oversize
`ifdef ETH_ARB_FRAME_CNT_EN
    ,
    output logic [CHANNELS*32-1:0]                frame_count
`endif
);

    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int GNT_W  = $clog2(CHANNELS);
    localparam int CNT_W  = $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    // Index of channel (base + off) modulo CHANNELS.
    function automatic logic [GNT_W-1:0] wrap_idx(input int base, input int off);
        int sum;
        sum = (base + off) % CHANNELS;
        return GNT_W'(sum);
    endfunction

    // Registered state
    state_t                 state_r;
    logic [GNT_W-1:0]       rr_ptr_r;
    logic [GNT_W-1:0]       grant_r;
    logic [CNT_W-1:0]       beat_cnt_r;
    logic [DATA_WIDTH-1:0]  m_tdata_r;
    logic [KEEP_W-1:0]      m_tkeep_r;
    logic [USER_WIDTH-1:0]  m_tuser_r;
    logic                   m_tvalid_r;
    logic                   m_tlast_r;
    logic [CHANNELS-1:0]    oversize_r;

    // Next-state values
    state_t                 state_s;
    logic [GNT_W-1:0]       rr_ptr_s;
    logic [GNT_W-1:0]       grant_s;
    logic [CNT_W-1:0]       beat_cnt_s;
    logic [DATA_WIDTH-1:0]  m_tdata_s;
    logic [KEEP_W-1:0]      m_tkeep_s;
    logic [USER_WIDTH-1:0]  m_tuser_s;
    logic                   m_tvalid_s;
    logic                   m_tlast_s;
    logic [CHANNELS-1:0]    oversize_s;

    // Datapath helpers
    logic [DATA_WIDTH-1:0]  sel_data_s;
    logic [KEEP_W-1:0]      sel_keep_s;
    logic [USER_WIDTH-1:0]  sel_user_s;
    logic                   sel_valid_s;
    logic                   sel_last_s;
    logic                   out_free_s;
    logic [CHANNELS-1:0]    tready_s;
    logic                   accept_s;
    logic [CNT_W-1:0]       beat_cnt_inc_s;
    logic                   hit_max_s;
    logic [GNT_W-1:0]       next_ptr_s;
    logic                   req_found_s;
    logic [GNT_W-1:0]       req_idx_s;
    logic [GNT_W-1:0]       cand_s;

    // Source of the granted channel
    assign sel_data_s  = s_axis_tdata[int'(grant_r)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_keep_s  = s_axis_tkeep[int'(grant_r)*KEEP_W +: KEEP_W];
    assign sel_user_s  = s_axis_tuser[int'(grant_r)*USER_WIDTH +: USER_WIDTH];
    assign sel_valid_s = s_axis_tvalid[grant_r];
    assign sel_last_s  = s_axis_tlast[grant_r];

    // The output register can take a new beat when empty or being drained now.
    assign out_free_s = (!m_tvalid_r) || m_axis_tready;

    assign accept_s = sel_valid_s && tready_s[grant_r];

    // Counter saturates at MAX_BEATS; in PASS it never exceeds MAX_BEATS-1.
    assign beat_cnt_inc_s = (beat_cnt_r == CNT_W'(MAX_BEATS)) ? beat_cnt_r
                                                              : beat_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    assign hit_max_s      = (beat_cnt_r == CNT_W'(MAX_BEATS - 1));

    assign next_ptr_s = (grant_r == GNT_W'(CHANNELS - 1)) ? {GNT_W{1'b0}}
                                                          : grant_r + {{(GNT_W-1){1'b0}}, 1'b1};

    // Round-robin search: first requester at or after rr_ptr.
    always_comb begin
        req_found_s = 1'b0;
        req_idx_s   = {GNT_W{1'b0}};
        cand_s      = {GNT_W{1'b0}};
        for (int k = 0; k < CHANNELS; k++) begin
            cand_s = wrap_idx(int'(rr_ptr_r), k);
            if (!req_found_s && s_axis_tvalid[cand_s]) begin
                req_found_s = 1'b1;
                req_idx_s   = cand_s;
            end else begin
                req_found_s = req_found_s;
            end
        end
    end

    // Per-channel ready: PASS follows output space, DROP always drains.
    always_comb begin
        tready_s = {CHANNELS{1'b0}};
        case (state_r)
            ST_PASS: tready_s[grant_r] = out_free_s;
            ST_DROP: tready_s[grant_r] = 1'b1;
            default: tready_s = {CHANNELS{1'b0}};
        endcase
    end

    // FSM next state, arbitration and output-register next values.
    always_comb begin
        state_s    = state_r;
        rr_ptr_s   = rr_ptr_r;
        grant_s    = grant_r;
        beat_cnt_s = beat_cnt_r;
        m_tdata_s  = m_tdata_r;
        m_tkeep_s  = m_tkeep_r;
        m_tuser_s  = m_tuser_r;
        m_tlast_s  = m_tlast_r;
        m_tvalid_s = m_tvalid_r && !m_axis_tready;
        oversize_s = {CHANNELS{1'b0}};

        case (state_r)
            ST_IDLE: begin
                if (req_found_s) begin
                    grant_s    = req_idx_s;
                    beat_cnt_s = {CNT_W{1'b0}};
                    state_s    = ST_PASS;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PASS: begin
                if (accept_s) begin
                    m_tvalid_s = 1'b1;
                    m_tdata_s  = sel_data_s;
                    m_tkeep_s  = sel_keep_s;
                    m_tuser_s  = sel_user_s;
                    m_tlast_s  = sel_last_s;
                    beat_cnt_s = beat_cnt_inc_s;
                    if (sel_last_s) begin
                        // A genuine end wins even on the MAX_BEATS-th beat.
                        rr_ptr_s = next_ptr_s;
                        state_s  = ST_IDLE;
                    end else if (hit_max_s) begin
                        // Cut the frame: close it here and flag it bad.
                        m_tlast_s           = 1'b1;
                        m_tuser_s[0]        = 1'b1;
                        oversize_s[grant_r] = 1'b1;
                        state_s             = ST_DROP;
                    end else begin
                        state_s = ST_PASS;
                    end
                end else begin
                    state_s = ST_PASS;
                end
            end
            ST_DROP: begin
                if (accept_s) begin
                    beat_cnt_s = beat_cnt_inc_s;
                    if (sel_last_s) begin
                        rr_ptr_s = next_ptr_s;
                        state_s  = ST_IDLE;
                    end else begin
                        state_s = ST_DROP;
                    end
                end else begin
                    state_s = ST_DROP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r    <= ST_IDLE;
            rr_ptr_r   <= {GNT_W{1'b0}};
            grant_r    <= {GNT_W{1'b0}};
            beat_cnt_r <= {CNT_W{1'b0}};
            m_tdata_r  <= {DATA_WIDTH{1'b0}};
            m_tkeep_r  <= {KEEP_W{1'b0}};
            m_tuser_r  <= {USER_WIDTH{1'b0}};
            m_tvalid_r <= 1'b0;
            m_tlast_r  <= 1'b0;
            oversize_r <= {CHANNELS{1'b0}};
        end else begin
            state_r    <= state_s;
            rr_ptr_r   <= rr_ptr_s;
            grant_r    <= grant_s;
            beat_cnt_r <= beat_cnt_s;
            m_tdata_r  <= m_tdata_s;
            m_tkeep_r  <= m_tkeep_s;
            m_tuser_r  <= m_tuser_s;
            m_tvalid_r <= m_tvalid_s;
            m_tlast_r  <= m_tlast_s;
            oversize_r <= oversize_s;
        end
    end

`ifdef ETH_ARB_FRAME_CNT_EN
    logic [CHANNELS*32-1:0] frame_cnt_r;
    logic                   frame_done_s;

    // A frame completes on a passed tlast or on truncation.
    assign frame_done_s = (state_r == ST_PASS) && accept_s && (sel_last_s || hit_max_s);

    // Per-channel completed-frame counters, wrapping at 2^32.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            frame_cnt_r <= {(CHANNELS*32){1'b0}};
        end else if (frame_done_s) begin
            frame_cnt_r[int'(grant_r)*32 +: 32] <= frame_cnt_r[int'(grant_r)*32 +: 32] + 32'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign frame_count = frame_cnt_r;
`endif

    assign s_axis_tready = tready_s;
    assign m_axis_tdata  = m_tdata_r;
    assign m_axis_tkeep  = m_tkeep_r;
    assign m_axis_tuser  = m_tuser_r;
    assign m_axis_tvalid = m_tvalid_r;
    assign m_axis_tlast  = m_tlast_r;
    assign grant         = grant_r;
    assign busy          = (state_r != ST_IDLE);
    assign oversize      = oversize_r;

endmodule

// File: tb/tb_eth_tx_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_eth_tx_port_arbiter
//
// Directed testbench for eth_tx_port_arbiter (CHANNELS=4, DATA_WIDTH=64,
// MAX_BEATS=4). Each source channel plays queued frames of given lengths;
// beat content encodes {channel, frame number, beat index} so every merged
// output beat can be compared against a hand-derived expectation.
// -----------------------------------------------------------------------------
module tb_eth_tx_port_arbiter;

    localparam int CH = 4;
    localparam int DW = 64;
    localparam int KW = 8;
    localparam int UW = 1;
    localparam int MB = 4;

    logic              clock = 1'b0;
    logic              resetn = 1'b0;
    logic [CH*DW-1:0]  s_axis_tdata = '0;
    logic [CH*KW-1:0]  s_axis_tkeep = '0;
    logic [CH*UW-1:0]  s_axis_tuser = '0;
    logic [CH-1:0]     s_axis_tvalid = '0;
    logic [CH-1:0]     s_axis_tlast = '0;
    logic [CH-1:0]     s_axis_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic [KW-1:0]     m_axis_tkeep;
    logic [UW-1:0]     m_axis_tuser;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready = 1'b1;
    logic [1:0]        grant;
    logic              busy;
    logic [CH-1:0]     oversize;
`ifdef ETH_ARB_FRAME_CNT_EN
    logic [CH*32-1:0]  frame_count;
`endif

    eth_tx_port_arbiter #(
        .CHANNELS(CH), .DATA_WIDTH(DW), .USER_WIDTH(UW), .MAX_BEATS(MB)
    ) dut (
        .clock(clock), .resetn(resetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tuser(s_axis_tuser), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .grant(grant), .busy(busy), .oversize(oversize)
`ifdef ETH_ARB_FRAME_CNT_EN
        , .frame_count(frame_count)
`endif
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;

    // Source model state
    int fq[CH][$];
    int fn[CH];
    int bi[CH];

    // Captured output transfers
    logic [63:0] got_d[$];
    logic [7:0]  got_k[$];
    logic        got_l[$];
    logic        got_u[$];
    int          got_t[$];
    int          cyc = 0;
    int          ov_n = 0;
    logic [3:0]  ov_v = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mkdata(input int c, input int f, input int b);
        return {32'hDA7A_0000, 8'(c), 8'(f), 16'(b)};
    endfunction

    function automatic logic [7:0] mkkeep(input int c, input int f, input int b);
        return 8'(c * 37 + f * 11 + b * 3);
    endfunction

    task automatic drive_src();
        for (int c = 0; c < CH; c++) begin
            if (fq[c].size() > 0) begin
                s_axis_tvalid[c]          = 1'b1;
                s_axis_tdata[c*DW +: DW]  = mkdata(c, fn[c], bi[c]);
                s_axis_tkeep[c*KW +: KW]  = mkkeep(c, fn[c], bi[c]);
                s_axis_tuser[c]           = 1'b0;
                s_axis_tlast[c]           = (bi[c] == fq[c][0] - 1);
            end else begin
                s_axis_tvalid[c]          = 1'b0;
                s_axis_tdata[c*DW +: DW]  = '0;
                s_axis_tkeep[c*KW +: KW]  = '0;
                s_axis_tuser[c]           = 1'b0;
                s_axis_tlast[c]           = 1'b0;
            end
        end
    endtask

    task automatic clear_src();
        for (int c = 0; c < CH; c++) begin
            fq[c].delete();
            fn[c] = 0;
            bi[c] = 0;
        end
    endtask

    task automatic clear_got();
        got_d.delete(); got_k.delete(); got_l.delete(); got_u.delete(); got_t.delete();
        ov_n = 0;
        ov_v = '0;
    endtask

    // One clock: sample handshakes before the edge, update sources after it.
    task automatic tick();
        logic [CH-1:0] acc;
        #1;
        acc = s_axis_tvalid & s_axis_tready;
        if (m_axis_tvalid && m_axis_tready) begin
            got_d.push_back(m_axis_tdata);
            got_k.push_back(m_axis_tkeep);
            got_l.push_back(m_axis_tlast);
            got_u.push_back(m_axis_tuser[0]);
            got_t.push_back(cyc);
        end
        @(posedge clock);
        #1;
        cyc++;
        if (oversize != '0) begin
            ov_n++;
            ov_v = oversize;
        end
        for (int c = 0; c < CH; c++) begin
            if (acc[c]) begin
                if (bi[c] == fq[c][0] - 1) begin
                    void'(fq[c].pop_front());
                    fn[c]++;
                    bi[c] = 0;
                end else begin
                    bi[c]++;
                end
            end
        end
        drive_src();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        m_axis_tready = 1'b1;
        clear_src();
        drive_src();
        @(posedge clock); #1;
        @(posedge clock); #1;
        resetn = 1'b1;
        clear_got();
    endtask

    task automatic run_until(input int want, input int budget);
        for (int i = 0; i < budget && got_d.size() < want; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int exp_ch[5];
        int exp_fn[5];
        exp_ch = '{0, 1, 2, 3, 0};
        exp_fn = '{0, 0, 0, 0, 1};

        // ---- Reset state, with a request pending during reset ----
        clear_src();
        clear_got();
        fq[0].push_back(1);
        drive_src();
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("rst_mvalid", m_axis_tvalid, 0);
        chk("rst_mdata",  m_axis_tdata, 0);
        chk("rst_mkeep",  m_axis_tkeep, 0);
        chk("rst_muser",  m_axis_tuser, 0);
        chk("rst_mlast",  m_axis_tlast, 0);
        chk("rst_sready", s_axis_tready, 0);
        chk("rst_busy",   busy, 0);
        chk("rst_grant",  grant, 0);
        chk("rst_ovs",    oversize, 0);
        resetn = 1'b1;
        run_until(1, 10);
        chk("rst_first_n", got_d.size(), 1);
        if (got_d.size() >= 1) begin
            chk("rst_first_data", got_d[0], mkdata(0, 0, 0));
            chk("rst_first_keep0", got_k[0], 8'h00);
            chk("rst_first_last", got_l[0], 1);
        end

        // ---- Round robin, 1-beat frames on all channels ----
        do_reset();
        fq[0].push_back(1); fq[0].push_back(1);
        fq[1].push_back(1); fq[2].push_back(1); fq[3].push_back(1);
        drive_src();
        run_until(5, 40);
        chk("rr_n", got_d.size(), 5);
        for (int i = 0; i < 5 && i < got_d.size(); i++) begin
            chk($sformatf("rr_data%0d", i), got_d[i], mkdata(exp_ch[i], exp_fn[i], 0));
            chk($sformatf("rr_keep%0d", i), got_k[i], mkkeep(exp_ch[i], exp_fn[i], 0));
            chk($sformatf("rr_last%0d", i), got_l[i], 1);
            if (i > 0) chk($sformatf("rr_gap%0d", i), got_t[i] - got_t[i-1], 2);
        end

        // ---- Backpressure on ch2 3-beat frame ----
        do_reset();
        fq[2].push_back(3);
        drive_src();
        for (int i = 0; i < 20 && !m_axis_tvalid; i++) tick();
        chk("bp_first_valid", m_axis_tvalid, 1);
        m_axis_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp_hold_data%0d", i), m_axis_tdata, mkdata(2, 0, 0));
            chk($sformatf("bp_hold_valid%0d", i), m_axis_tvalid, 1);
            chk($sformatf("bp_sready%0d", i), s_axis_tready[2], 0);
        end
        chk("bp_src_stalled", bi[2], 1);
        m_axis_tready = 1'b1;
        run_until(3, 20);
        chk("bp_n", got_d.size(), 3);
        for (int i = 0; i < 3 && i < got_d.size(); i++) begin
            chk($sformatf("bp_data%0d", i), got_d[i], mkdata(2, 0, i));
            chk($sformatf("bp_last%0d", i), got_l[i], (i == 2) ? 1 : 0);
        end

        // ---- Truncation: 6-beat frame on ch1, MAX_BEATS=4 ----
        do_reset();
        fq[1].push_back(6);
        drive_src();
        for (int i = 0; i < 20; i++) tick();
        chk("trunc_n", got_d.size(), 4);
        for (int i = 0; i < 4 && i < got_d.size(); i++) begin
            chk($sformatf("trunc_data%0d", i), got_d[i], mkdata(1, 0, i));
            chk($sformatf("trunc_last%0d", i), got_l[i], (i == 3) ? 1 : 0);
            chk($sformatf("trunc_user%0d", i), got_u[i], (i == 3) ? 1 : 0);
        end
        chk("trunc_ov_pulses", ov_n, 1);
        chk("trunc_ov_chan", ov_v, 4'b0010);
        chk("trunc_drained", fq[1].size(), 0);
        chk("trunc_idle", busy, 0);

        // ---- Exactly MAX_BEATS beats: no truncation ----
        do_reset();
        fq[0].push_back(4);
        drive_src();
        for (int i = 0; i < 20; i++) tick();
        chk("exact_n", got_d.size(), 4);
        for (int i = 0; i < 4 && i < got_d.size(); i++) begin
            chk($sformatf("exact_last%0d", i), got_l[i], (i == 3) ? 1 : 0);
            chk($sformatf("exact_user%0d", i), got_u[i], 0);
        end
        chk("exact_ov_pulses", ov_n, 0);

        // ---- Reset mid-frame; pointer returns to ch0 ----
        do_reset();
        fq[1].push_back(1);
        drive_src();
        run_until(1, 10);
        fq[2].push_back(5);
        drive_src();
        for (int i = 0; i < 20 && bi[2] != 1; i++) tick();
        chk("mid_at_beat2", bi[2], 1);
        resetn = 1'b0;
        clear_src();
        drive_src();
        @(posedge clock); #1;
        chk("mid_mvalid", m_axis_tvalid, 0);
        chk("mid_mdata", m_axis_tdata, 0);
        chk("mid_mlast", m_axis_tlast, 0);
        chk("mid_busy", busy, 0);
        chk("mid_grant", grant, 0);
        chk("mid_sready", s_axis_tready, 0);
        resetn = 1'b1;
        clear_got();
        fq[0].push_back(1);
        fq[3].push_back(1);
        drive_src();
        run_until(2, 20);
        chk("mid_after_n", got_d.size(), 2);
        if (got_d.size() >= 2) begin
            chk("mid_after_first", got_d[0], mkdata(0, 0, 0));
            chk("mid_after_second", got_d[1], mkdata(3, 0, 0));
        end

`ifdef ETH_ARB_FRAME_CNT_EN
        // ---- Frame counters ----
        do_reset();
        fq[0].push_back(1); fq[0].push_back(1); fq[0].push_back(1);
        fq[3].push_back(6);
        drive_src();
        for (int i = 0; i < 40; i++) tick();
        chk("fc_ch0", frame_count[0*32 +: 32], 3);
        chk("fc_ch1", frame_count[1*32 +: 32], 0);
        chk("fc_ch2", frame_count[2*32 +: 32], 0);
        chk("fc_ch3", frame_count[3*32 +: 32], 1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/eth_tx_port_arbiter.md
ETH_TX_PORT_ARBITER -- requirements
Module: eth_tx_port_arbiter

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of AXIS TX source channels (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 64, tdata width; keep width DATA_WIDTH/8.
REQ-003 SHALL have parameter USER_WIDTH, default 1, tuser width; bit 0 is the bad-frame flag.
REQ-004 SHALL have parameter MAX_BEATS, default 1152, maximum beats per frame (9214-byte MTU at 64 bits).
REQ-005 SHALL have port clock  in  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port resetn  in  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have ports s_axis_tdata/tkeep/tuser  in  CHANNELS x (DATA_WIDTH/KEEP/USER_WIDTH)  flattened per-channel source data; channel i at slice i.
REQ-008 SHALL have ports s_axis_tvalid, s_axis_tlast  in  CHANNELS  per-channel valid and last.
REQ-009 SHALL have port s_axis_tready  out  CHANNELS  per-channel ready.
REQ-010 SHALL have ports m_axis_tdata/tkeep/tuser/tvalid/tlast  out, and m_axis_tready  in  merged stream to the MAC TX FIFO.
REQ-011 SHALL have port grant  out  clog2(CHANNELS)  currently or last granted channel.
REQ-012 SHALL have port busy  out  1  high while state is not IDLE.
REQ-013 SHALL have port oversize  out  CHANNELS  one-cycle pulse per channel on frame truncation.

Function
REQ-014 SHALL implement states IDLE, PASS, DROP.
REQ-015 IDLE: if any s_axis_tvalid, SHALL grant the first requesting channel at or after rr_ptr (mod CHANNELS), load grant, clear beat counter, go PASS next cycle; no beat accepted in IDLE.
REQ-016 SHALL keep arbitration frame-atomic: grant never changes in PASS or DROP.
REQ-017 SHALL assert s_axis_tready[grant] in PASS only when m_axis_tvalid==0 or m_axis_tready==1; all other tready bits 0.
REQ-018 SHALL register output: an accepted beat appears on m_axis one cycle later; full throughput (1 beat/cycle) when m_axis_tready stays high.
REQ-019 SHALL hold m_axis_* stable while m_axis_tvalid && !m_axis_tready; clear m_axis_tvalid after a transfer with no new beat.
REQ-020 SHALL forward tdata, tkeep, tuser, tlast unchanged, including beats with tkeep==0.
REQ-021 PASS: on accepted beat with tlast, SHALL set rr_ptr = grant+1 (wrap CHANNELS-1 -> 0) and go IDLE; inter-frame gap exactly one cycle.
REQ-022 SHALL count accepted beats; counter width clog2(MAX_BEATS+1), never wraps.
REQ-023 If the MAX_BEATS-th beat is accepted without tlast, SHALL output it with tlast=1 and tuser[0]=1, pulse oversize[grant] one cycle, go DROP.
REQ-024 DROP: SHALL hold s_axis_tready[grant]=1 regardless of m_axis_tready, discard beats, and on accepted tlast set rr_ptr=grant+1 and go IDLE.
REQ-025 A frame whose tlast coincides with beat MAX_BEATS SHALL pass unmodified (no truncation, no pulse).
REQ-026 Requests raised while another channel is granted SHALL wait; a channel deasserting tvalid mid-frame SHALL stall the stream, not release the grant.

Reset
REQ-027 While resetn==0: state IDLE, rr_ptr 0, grant 0, beat counter 0, m_axis_tvalid 0, m_axis_tdata/tkeep/tuser/tlast 0, s_axis_tready 0, busy 0, oversize 0.
REQ-028 Reset mid-frame SHALL abandon the frame with no terminating beat; release SHALL be synchronised externally to clock.

Configuration
REQ-029 Macro ETH_ARB_FRAME_CNT_EN defined: SHALL add output frame_count (CHANNELS x 32) counting frames completed per channel (PASS tlast or truncation), wrap at 2^32, reset to 0.
REQ-030 Macro undefined: SHALL omit frame_count port and counters; all other behaviour identical.

Verification
REQ-031 CHANNELS=4, all tvalid high with 1-beat frames, m_axis_tready=1 -> output order ch0,ch1,ch2,ch3,ch0; one idle cycle between frames.
REQ-032 ch2 sends 3-beat frame, m_axis_tready low for 5 cycles after first output -> m_axis data held stable, s_axis_tready[2]=0, all 3 beats delivered in order.
REQ-033 MAX_BEATS=4, ch1 sends 6-beat frame -> 4 beats out, 4th with tlast=1 tuser[0]=1, oversize[1] pulses one cycle, beats 5-6 drained with no output.
REQ-034 MAX_BEATS=4, exactly 4-beat frame -> delivered unmodified, oversize stays 0.
REQ-035 resetn low during beat 2 of a 5-beat frame -> all outputs 0 next edge; after release, ch0 granted first.
REQ-036 With ETH_ARB_FRAME_CNT_EN, 3 frames on ch0 and 1 truncated on ch3 -> frame_count ch0=3, ch3=1, others 0.
